// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Moore control FSM for a MIPS-style multicycle datapath. It sequences
// fetch, decode, memory, execute, branch and jump steps, flags illegal opcodes,
// and counts retired instructions.
//
// Optional feature (compile-time macro MEM_WAIT_EN):
//   defined   - FETCH, MEMRD and MEMWR hold until mem_ready=1. IRWrite,
//               PCWrite (FETCH) and instr_done (MEMWR) assert only in the
//               mem_ready=1 cycle.
//   undefined - mem_ready is ignored. Each memory state lasts one cycle.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   opcode[5:0]   IR[31:26], stable from DECODE until the instruction ends
//   zero          ALU zero flag, used in BRANCH
//   mem_ready     memory completion strobe (only used with MEM_WAIT_EN)
//   PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
//   ALUSrcA, ALUSrcB[1:0], PCSource[1:0], AluOP[3:0]
//                 datapath controls
//   state[3:0]    current FSM state encoding
//   trap          illegal-opcode indication (held until reset)
//   instr_done    one-cycle pulse on the last cycle of each instruction
//   instr_count   retired-instruction count, wraps at 16 bits
// -----------------------------------------------------------------------------
module multicycle_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        PCWrite,
   output logic        IorD,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        RegDst,
   output logic        MemtoReg,
   output logic        RegWrite,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  PCSource,
   output logic [3:0]  AluOP,
   output logic [3:0]  state,
   output logic        trap,
   output logic        instr_done,
   output logic [15:0] instr_count
);

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      FETCH  = 4'd1,
      DECODE = 4'd2,
      MEMADR = 4'd3,
      MEMRD  = 4'd4,
      MEMWB  = 4'd5,
      MEMWR  = 4'd6,
      EXEC   = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9,
      JUMP   = 4'd10,
      TRAP   = 4'd11
   } stateT;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   stateT       curState;
   stateT       nextState;
   logic [5:0]  opReg;
   logic [15:0] instrCount;
   logic        memDone;

`ifdef MEM_WAIT_EN
   assign memDone = mem_ready;
`else
   // Memory always completes in one cycle; the strobe is intentionally unused.
   logic unusedMemReady;
   assign unusedMemReady = mem_ready;
   assign memDone        = 1'b1;
`endif

   assign state       = curState;
   assign instr_count = instrCount;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         curState   <= IDLE;
         opReg      <= '0;
         instrCount <= '0;
      end else begin
         curState <= nextState;
         if (curState == DECODE) opReg <= opcode;
         // Trapped instructions never pulse instr_done, so they are not counted.
         if (instr_done) instrCount <= instrCount + 16'd1;
      end
   end

   // NOTE: every output and nextState gets a default before the case, so no
   // path through this block can leave a signal unassigned and infer a latch.
   always_comb begin
      nextState  = curState;
      PCWrite    = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      PCSource   = 2'b00;
      AluOP      = 4'b0000;
      trap       = 1'b0;
      instr_done = 1'b0;

      case (curState)
         IDLE: nextState = FETCH;

         FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            if (memDone) begin
               IRWrite   = 1'b1;
               PCWrite   = 1'b1;
               nextState = DECODE;
            end
         end

         DECODE: begin
            ALUSrcB = 2'b11;
            // opReg is loaded on this edge, so dispatch uses the live opcode.
            case (opcode)
               OP_LW, OP_SW:                  nextState = MEMADR;
               OP_RTYPE, OP_ANDI, OP_ORI, OP_XORI,
               OP_ADDI, OP_SLTI, OP_LUI:      nextState = EXEC;
               OP_BEQ, OP_BNE:                nextState = BRANCH;
               OP_J:                          nextState = JUMP;
               default:                       nextState = TRAP;
            endcase
         end

         MEMADR: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            nextState = (opReg == OP_SW) ? MEMWR : MEMRD;
         end

         MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (memDone) nextState = MEMWB;
         end

         MEMWB: begin
            MemtoReg   = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
            nextState  = FETCH;
         end

         MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (memDone) begin
               instr_done = 1'b1;
               nextState  = FETCH;
            end
         end

         EXEC: begin
            ALUSrcA   = 1'b1;
            nextState = ALUWB;
            if (opReg == OP_RTYPE) begin
               ALUSrcB = 2'b00;
               AluOP   = 4'b1000;
            end else begin
               ALUSrcB = 2'b10;
               case (opReg)
                  OP_ANDI: AluOP = 4'b0001;
                  OP_ORI:  AluOP = 4'b0010;
                  OP_XORI: AluOP = 4'b0011;
                  OP_ADDI: AluOP = 4'b0101;
                  OP_LUI:  AluOP = 4'b1010;
                  OP_SLTI: AluOP = 4'b1011;
                  default: AluOP = 4'b0000;
               endcase
            end
         end

         ALUWB: begin
            RegWrite   = 1'b1;
            RegDst     = (opReg == OP_RTYPE);
            instr_done = 1'b1;
            nextState  = FETCH;
         end

         BRANCH: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b00;
            AluOP      = 4'b0110;
            PCSource   = 2'b01;
            // Taken when zero for beq, when non-zero for bne.
            PCWrite    = zero ^ (opReg == OP_BNE);
            instr_done = 1'b1;
            nextState  = FETCH;
         end

         JUMP: begin
            PCSource   = 2'b10;
            PCWrite    = 1'b1;
            instr_done = 1'b1;
            nextState  = FETCH;
         end

         TRAP: trap = 1'b1;

         default: nextState = IDLE;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl. Each scenario task drives opcodes,
// walks the expected state sequence and compares the control outputs inline.
// Every instruction issued pushes its expected final state and retire count
// into a scoreboard, which a monitor pops on each instr_done pulse.
// Build with +define+MEM_WAIT_EN to exercise the memory-wait variant.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BAD   = 6'b111111;

   // Control vector order:
   // PCWrite IorD MemRead MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA
   // ALUSrcB[1:0] PCSource[1:0] AluOP[3:0] trap instr_done
   localparam logic [18:0] CTL_FETCH   = 19'b1_0_1_0_1_0_0_0_0_01_00_0000_0_0;
   localparam logic [18:0] CTL_DECODE  = 19'b0_0_0_0_0_0_0_0_0_11_00_0000_0_0;
   localparam logic [18:0] CTL_EXEC_R  = 19'b0_0_0_0_0_0_0_0_1_00_00_1000_0_0;
   localparam logic [18:0] CTL_ALUWB_R = 19'b0_0_0_0_0_1_0_1_0_00_00_0000_0_1;
   localparam logic [18:0] CTL_ALUWB_I = 19'b0_0_0_0_0_0_0_1_0_00_00_0000_0_1;
   localparam logic [18:0] CTL_MEMADR  = 19'b0_0_0_0_0_0_0_0_1_10_00_0000_0_0;
   localparam logic [18:0] CTL_MEMRD   = 19'b0_1_1_0_0_0_0_0_0_00_00_0000_0_0;
   localparam logic [18:0] CTL_MEMWB   = 19'b0_0_0_0_0_0_1_1_0_00_00_0000_0_1;
   localparam logic [18:0] CTL_MEMWR   = 19'b0_1_0_1_0_0_0_0_0_00_00_0000_0_1;
   localparam logic [18:0] CTL_JUMP    = 19'b1_0_0_0_0_0_0_0_0_00_10_0000_0_1;
   localparam logic [18:0] CTL_TRAP    = 19'b0_0_0_0_0_0_0_0_0_00_00_0000_1_0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  opcode;
   logic        zero;
   logic        mem_ready;
   logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst;
   logic        MemtoReg, RegWrite, ALUSrcA;
   logic [1:0]  ALUSrcB, PCSource;
   logic [3:0]  AluOP;
   logic [3:0]  state;
   logic        trap, instr_done;
   logic [15:0] instr_count;

   typedef struct packed {
      logic [3:0]  st;
      logic [15:0] cnt;
   } expT;

   expT         sbQ[$];
   logic [15:0] modelCount;
   int          checks = 0;
   int          errors = 0;

   multicycle_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .opcode      (opcode),
      .zero        (zero),
      .mem_ready   (mem_ready),
      .PCWrite     (PCWrite),
      .IorD        (IorD),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .IRWrite     (IRWrite),
      .RegDst      (RegDst),
      .MemtoReg    (MemtoReg),
      .RegWrite    (RegWrite),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .PCSource    (PCSource),
      .AluOP       (AluOP),
      .state       (state),
      .trap        (trap),
      .instr_done  (instr_done),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [18:0] ctrlVec();
      return {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
              RegWrite, ALUSrcA, ALUSrcB, PCSource, AluOP, trap, instr_done};
   endfunction

   // Scoreboard consumer: each retirement must match the oldest issued entry.
   always @(negedge clk) begin
      expT e;
      if (rst_n && instr_done) begin
         checks++;
         if (sbQ.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_done: state=%0d count=%h, nothing outstanding",
                     state, instr_count);
         end else begin
            e = sbQ.pop_front();
            if ({state, instr_count} !== {e.st, e.cnt}) begin
               errors++;
               $display("FAIL sb_retire: state=%0d count=%h, expected state=%0d count=%h",
                        state, instr_count, e.st, e.cnt);
            end
         end
      end
   end

   // Called at a negedge whose following edge enters FETCH.
   task automatic issue(input logic [5:0] opc, input logic z, input logic [3:0] finalSt);
      expT e;
      opcode = opc;
      zero   = z;
      e.st   = finalSt;
      e.cnt  = modelCount;
      sbQ.push_back(e);
      modelCount = modelCount + 16'd1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      opcode    = OP_RTYPE;
      zero      = 1'b0;
      mem_ready = 1'b1;
      sbQ.delete();
      modelCount = 16'd0;
      repeat (2) @(negedge clk);
      checks++;
      if (state !== 4'd0) begin
         errors++;
         $display("FAIL reset_state: got %0d, expected 0", state);
      end
      checks++;
      if (ctrlVec() !== 19'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b, expected all 0", ctrlVec());
      end
      checks++;
      if (instr_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_count: got %h, expected 0000", instr_count);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_rtype();
      logic [3:0]  expSt  [4] = '{4'd1, 4'd2, 4'd7, 4'd8};
      logic [18:0] expCtl [4] = '{CTL_FETCH, CTL_DECODE, CTL_EXEC_R, CTL_ALUWB_R};
      logic [15:0] cntStart;
      cntStart = modelCount;
      issue(OP_RTYPE, 1'b0, 4'd8);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if ({state, ctrlVec()} !== {expSt[i], expCtl[i]}) begin
            errors++;
            $display("FAIL rtype_step%0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                     i, state, ctrlVec(), expSt[i], expCtl[i]);
         end
         if (i == 0) begin
            checks++;
            if (instr_count !== cntStart) begin
               errors++;
               $display("FAIL rtype_count: got %h, expected %h", instr_count, cntStart);
            end
         end
      end
   endtask

   task automatic test_itype();
      logic [5:0] ops   [6] = '{6'b001100, 6'b001101, 6'b001110, 6'b001000, 6'b001111, 6'b001010};
      logic [3:0] alus  [6] = '{4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b1010, 4'b1011};
      logic [3:0]  expSt  [4] = '{4'd1, 4'd2, 4'd7, 4'd8};
      logic [18:0] expCtl [4];
      logic [15:0] cntStart;
      for (int k = 0; k < 6; k++) begin
         expCtl[0] = CTL_FETCH;
         expCtl[1] = CTL_DECODE;
         expCtl[2] = {9'b0_0_0_0_0_0_0_0_1, 2'b10, 2'b00, alus[k], 2'b00};
         expCtl[3] = CTL_ALUWB_I;
         cntStart  = modelCount;
         issue(ops[k], 1'b0, 4'd8);
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({state, ctrlVec()} !== {expSt[i], expCtl[i]}) begin
               errors++;
               $display("FAIL itype_op%b_step%0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                        ops[k], i, state, ctrlVec(), expSt[i], expCtl[i]);
            end
            if (i == 0) begin
               checks++;
               if (instr_count !== cntStart) begin
                  errors++;
                  $display("FAIL itype_count: got %h, expected %h", instr_count, cntStart);
               end
            end
         end
      end
   endtask

   // mem_ready is dropped for the first MEMRD cycles; the wait build must
   // stretch MEMRD to three cycles, the default build must ignore it.
   task automatic test_lw();
`ifdef MEM_WAIT_EN
      logic [3:0]  expSt  [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5};
      logic [18:0] expCtl [7] = '{CTL_FETCH, CTL_DECODE, CTL_MEMADR, CTL_MEMRD,
                                  CTL_MEMRD, CTL_MEMRD, CTL_MEMWB};
`else
      logic [3:0]  expSt  [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
      logic [18:0] expCtl [5] = '{CTL_FETCH, CTL_DECODE, CTL_MEMADR, CTL_MEMRD, CTL_MEMWB};
`endif
      issue(OP_LW, 1'b0, 4'd5);
      for (int i = 0; i < $size(expSt); i++) begin
         @(negedge clk);
         checks++;
         if ({state, ctrlVec()} !== {expSt[i], expCtl[i]}) begin
            errors++;
            $display("FAIL lw_step%0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                     i, state, ctrlVec(), expSt[i], expCtl[i]);
         end
         if (i == 2) mem_ready = 1'b0;
         if (i == $size(expSt) - 2) mem_ready = 1'b1;
      end
   endtask

   task automatic test_sw();
      logic [3:0]  expSt  [4] = '{4'd1, 4'd2, 4'd3, 4'd6};
      logic [18:0] expCtl [4] = '{CTL_FETCH, CTL_DECODE, CTL_MEMADR, CTL_MEMWR};
      issue(OP_SW, 1'b0, 4'd6);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if ({state, ctrlVec()} !== {expSt[i], expCtl[i]}) begin
            errors++;
            $display("FAIL sw_step%0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                     i, state, ctrlVec(), expSt[i], expCtl[i]);
         end
      end
   endtask

   task automatic test_branch();
      logic [5:0] ops   [4] = '{OP_BEQ, OP_BNE, OP_BEQ, OP_BNE};
      logic       zs    [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic       taken [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [3:0]  expSt  [3] = '{4'd1, 4'd2, 4'd9};
      logic [18:0] expCtl [3];
      for (int k = 0; k < 4; k++) begin
         expCtl[0] = CTL_FETCH;
         expCtl[1] = CTL_DECODE;
         expCtl[2] = {taken[k], 18'b0_0_0_0_0_0_0_1_00_01_0110_0_1};
         issue(ops[k], zs[k], 4'd9);
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({state, ctrlVec()} !== {expSt[i], expCtl[i]}) begin
               errors++;
               $display("FAIL branch_op%b_z%0d_step%0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                        ops[k], zs[k], i, state, ctrlVec(), expSt[i], expCtl[i]);
            end
         end
      end
   endtask

   task automatic test_jump();
      logic [3:0]  expSt  [3] = '{4'd1, 4'd2, 4'd10};
      logic [18:0] expCtl [3] = '{CTL_FETCH, CTL_DECODE, CTL_JUMP};
      issue(OP_J, 1'b0, 4'd10);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({state, ctrlVec()} !== {expSt[i], expCtl[i]}) begin
            errors++;
            $display("FAIL jump_step%0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                     i, state, ctrlVec(), expSt[i], expCtl[i]);
         end
      end
   endtask

   // The counter is preloaded near the top instead of retiring 65533 jumps;
   // three real jumps then carry it through 0xFFFF to 0x0000. Ends at the
   // following FETCH negedge with an R-type opcode presented.
   task automatic test_wrap();
      logic [3:0]  expSt  [3] = '{4'd1, 4'd2, 4'd10};
      logic [18:0] expCtl [3] = '{CTL_FETCH, CTL_DECODE, CTL_JUMP};
      logic [15:0] cntStart;
      for (int k = 0; k < 3; k++) begin
         if (k == 0) begin
            opcode = OP_J;
            zero   = 1'b0;
            @(posedge clk);
            #1;
            force dut.instrCount = 16'hFFFD;
            #1;
            release dut.instrCount;
            modelCount = 16'hFFFD;
         end
         cntStart = modelCount;
         issue(OP_J, 1'b0, 4'd10);
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({state, ctrlVec()} !== {expSt[i], expCtl[i]}) begin
               errors++;
               $display("FAIL wrap_j%0d_step%0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                        k, i, state, ctrlVec(), expSt[i], expCtl[i]);
            end
            if (i == 0) begin
               checks++;
               if (instr_count !== cntStart) begin
                  errors++;
                  $display("FAIL wrap_count_j%0d: got %h, expected %h", k, instr_count, cntStart);
               end
            end
         end
      end
      @(negedge clk);
      opcode = OP_RTYPE;
      checks++;
      if ({state, instr_count} !== {4'd1, modelCount}) begin
         errors++;
         $display("FAIL wrap_to_zero: state=%0d count=%h, expected state=1 count=%h",
                  state, instr_count, modelCount);
      end
   endtask

   // Starts in FETCH of an R-type; reset hits while in EXEC.
   task automatic test_reset_mid();
      repeat (2) @(negedge clk);
      checks++;
      if (state !== 4'd7) begin
         errors++;
         $display("FAIL midreset_pre_state: got %0d, expected 7", state);
      end
      rst_n = 1'b0;
      sbQ.delete();
      modelCount = 16'd0;
      #1;
      checks++;
      if ({state, ctrlVec(), instr_count} !== {4'd0, 19'd0, 16'd0}) begin
         errors++;
         $display("FAIL midreset_async: state=%0d ctrl=%b count=%h, expected all 0",
                  state, ctrlVec(), instr_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_trap();
      logic [3:0]  expSt  [3] = '{4'd1, 4'd2, 4'd11};
      logic [18:0] expCtl [3] = '{CTL_FETCH, CTL_DECODE, CTL_TRAP};
      logic [15:0] cntStart;
      cntStart = modelCount;
      opcode   = OP_BAD;
      zero     = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({state, ctrlVec()} !== {expSt[i], expCtl[i]}) begin
            errors++;
            $display("FAIL trap_step%0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                     i, state, ctrlVec(), expSt[i], expCtl[i]);
         end
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks++;
         if ({state, ctrlVec()} !== {4'd11, CTL_TRAP}) begin
            errors++;
            $display("FAIL trap_hold_cycle%0d: state=%0d ctrl=%b, expected state=11 ctrl=%b",
                     c, state, ctrlVec(), CTL_TRAP);
         end
      end
      checks++;
      if (instr_count !== cntStart) begin
         errors++;
         $display("FAIL trap_count: got %h, expected %h", instr_count, cntStart);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_rtype();
      test_itype();
      test_lw();
      test_sw();
      test_branch();
      test_jump();
      test_wrap();
      test_reset_mid();
      test_jump();
      test_trap();
      checks++;
      if (sbQ.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d instructions never retired, expected 0", sbQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
